// File: rtl/fdd_track_sequencer.sv
// Disk II track buffer sequencer: loads a whole track from the SD image,
// flushes a modified track back first, and stalls the CPU while busy.
module fdd_track_sequencer #(
    parameter int SECTORS = 13,
    parameter int TRACK_W = 6
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic [TRACK_W-1:0] track,
    input  logic               img_mounted,
    input  logic               img_present,
    input  logic               img_readonly,
    input  logic               buf_we,
    input  logic               sd_ack,
    output logic               sd_rd,
    output logic               sd_wr,
    output logic [31:0]        sd_lba,
    output logic [3:0]         track_sec,
    output logic               cpu_wait,
    output logic               dirty
);

    typedef enum logic [2:0] {
        IDLE,
        WREQ,
        WXFER,
        RREQ,
        RXFER
    } state_t;

    localparam logic [3:0] LAST = 4'(SECTORS - 1);

    state_t             state;
    logic [3:0]         sec;
    logic [TRACK_W-1:0] cur_trk;
    logic [TRACK_W-1:0] tgt;
    logic               loaded_valid;
    logic               old_ack;

    logic ack_rise;
    logic ack_fall;
    logic need_load;
    logic [3:0] sec_next;

    function automatic logic [31:0] lba_of(input logic [TRACK_W-1:0] t,
                                           input logic [3:0] s);
        return 32'(SECTORS) * 32'(t) + 32'(s);
    endfunction

    // Edge detection on the acknowledge and the track-mismatch test.
    // A still-high ack from an aborted transfer blocks new requests.
    always_comb begin
        ack_rise  = sd_ack & ~old_ack;
        ack_fall  = ~sd_ack & old_ack;
        need_load = img_present & ~sd_ack &
                    (~loaded_valid | (track != cur_trk));
        sec_next  = sec + 4'd1;
    end

    // Sequencer state machine with registered request/stall outputs.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            sec          <= 4'd0;
            cur_trk      <= '0;
            tgt          <= '0;
            loaded_valid <= 1'b0;
            old_ack      <= 1'b0;
            sd_rd        <= 1'b0;
            sd_wr        <= 1'b0;
            sd_lba       <= 32'd0;
            track_sec    <= 4'd0;
            cpu_wait     <= 1'b0;
            dirty        <= 1'b0;
        end else begin
            old_ack <= sd_ack;
            if (buf_we & loaded_valid & ~img_readonly) begin
                dirty <= 1'b1;
            end
            if (img_mounted) begin
                dirty        <= 1'b0;
                loaded_valid <= 1'b0;
                sd_rd        <= 1'b0;
                sd_wr        <= 1'b0;
                cpu_wait     <= 1'b0;
                sec          <= 4'd0;
                track_sec    <= 4'd0;
                state        <= IDLE;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (need_load) begin
                            sec       <= 4'd0;
                            track_sec <= 4'd0;
                            cpu_wait  <= 1'b1;
                            if (dirty & loaded_valid) begin
                                sd_wr  <= 1'b1;
                                sd_lba <= lba_of(cur_trk, 4'd0);
                                state  <= WREQ;
                            end else begin
                                sd_rd  <= 1'b1;
                                tgt    <= track;
                                sd_lba <= lba_of(track, 4'd0);
                                state  <= RREQ;
                            end
                        end
                    end
                    WREQ: begin
                        if (ack_rise) begin
                            sd_wr <= 1'b0;
                            state <= WXFER;
                        end
                    end
                    WXFER: begin
                        if (ack_fall) begin
                            if (sec == LAST) begin
                                dirty     <= 1'b0;
                                sec       <= 4'd0;
                                track_sec <= 4'd0;
                                tgt       <= track;
                                sd_lba    <= lba_of(track, 4'd0);
                                sd_rd     <= 1'b1;
                                state     <= RREQ;
                            end else begin
                                sec       <= sec_next;
                                track_sec <= sec_next;
                                sd_lba    <= lba_of(cur_trk, sec_next);
                                sd_wr     <= 1'b1;
                                state     <= WREQ;
                            end
                        end
                    end
                    RREQ: begin
                        if (ack_rise) begin
                            sd_rd <= 1'b0;
                            state <= RXFER;
                        end
                    end
                    RXFER: begin
                        if (ack_fall) begin
                            if (sec == LAST) begin
                                cur_trk      <= tgt;
                                loaded_valid <= 1'b1;
                                cpu_wait     <= 1'b0;
                                state        <= IDLE;
                            end else begin
                                sec       <= sec_next;
                                track_sec <= sec_next;
                                sd_lba    <= lba_of(tgt, sec_next);
                                sd_rd     <= 1'b1;
                                state     <= RREQ;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
